// File: rtl/booth_r4_ctrl.sv
// Control sequencer for a radix-4 Booth multiplier datapath (A/Q/M registers, adder, outbus).
// Latency: OPW+3 cycles from the start-sampling edge to the OUT cycle; back in IDLE at OPW+4.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   start           request a multiplication (IDLE only)
//   qbits           {Q[1], Q[0], Q[-1]} read back from the datapath
//   c0..c7          datapath strobes (clear/load Q, load M, load A, subtract, 2M, shift, drive outbus)
//   busy, done      busy from INIT through OUT; done pulses in OUT
module booth_r4_ctrl #(
    parameter int OPW = 8
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       start,
    input  logic [2:0] qbits,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       busy,
    output logic       done
);

    localparam int ITER = OPW / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOADM  = 3'd2,
        RECODE = 3'd3,
        SHIFT  = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c0      = 1'b0;
        c1      = 1'b0;
        c2      = 1'b0;
        c3      = 1'b0;
        c4      = 1'b0;
        c5      = 1'b0;
        c6      = 1'b0;
        c7      = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = INIT;
            end
            INIT: begin
                c0      = 1'b1;
                cnt_d   = '0;
                state_d = LOADM;
            end
            LOADM: begin
                c1      = 1'b1;
                state_d = RECODE;
            end
            RECODE: begin
                // qbits come straight from datapath registers, so gating the
                // Moore strobes with them is glitch-free for the whole cycle.
                unique case (qbits)
                    3'b001, 3'b010: c2 = 1'b1;                          // +M
                    3'b011:         begin c2 = 1'b1; c4 = 1'b1; end     // +2M
                    3'b100:         begin c2 = 1'b1; c3 = 1'b1; c4 = 1'b1; end // -2M
                    3'b101, 3'b110: begin c2 = 1'b1; c3 = 1'b1; end     // -M
                    default:        ;                                   // 000/111: no add
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                c5 = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = OUT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RECODE;
                end
            end
            OUT: begin
                c6      = 1'b1;
                c7      = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Directed bench for booth_r4_ctrl with a behavioural A/Q/M datapath for end-to-end products.
// Latency: checks OUT at cycle OPW+3 (11) after the start-sampling edge.
// Backpressure: none; start pulses during busy are checked to be ignored.
module tb_booth_r4_ctrl;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic [2:0] qbits;
    logic       c0, c1, c2, c3, c4, c5, c6, c7, busy, done;

    int checks = 0;
    int errors = 0;

    // Datapath model
    logic              use_dp;
    logic [2:0]        qbits_tb;
    logic [7:0]        mplier, mcand;
    logic [7:0]        inbus;
    logic [9:0]        a_r;
    logic [7:0]        q_r, m_r;
    logic              qm1_r;
    logic [9:0]        operand;
    logic signed [18:0] shifted;
    logic [16:0]       outbus;

    booth_r4_ctrl #(.OPW(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .qbits (qbits),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .c7    (c7),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        inbus   = c0 ? mplier : mcand;
        operand = c4 ? {m_r[7], m_r, 1'b0} : {{2{m_r[7]}}, m_r};
        shifted = $signed({a_r, q_r, qm1_r}) >>> 2;
        outbus  = {(c6 ? a_r[8:0] : 9'd0), (c7 ? q_r : 8'd0)};
        qbits   = use_dp ? {q_r[1], q_r[0], qm1_r} : qbits_tb;
    end

    always_ff @(posedge clk) begin
        if (c0) begin
            a_r   <= '0;
            qm1_r <= 1'b0;
            q_r   <= inbus;
        end
        if (c1) m_r <= inbus;
        if (c2) a_r <= c3 ? (a_r - operand) : (a_r + operand);
        if (c5) {a_r, q_r, qm1_r} <= shifted;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {c0, c1, c2, c3, c4, c5, c6, c7, busy, done};
    endfunction

    // Expected {c0..c7,busy,done} for cycle k after start, qbits = 000.
    function automatic logic [9:0] exp_vec(input int k);
        if (k == 1)                         return 10'b1000000010;
        if (k == 2)                         return 10'b0100000010;
        if (k >= 3 && k <= 10 && k[0])      return 10'b0000000010;
        if (k >= 4 && k <= 10 && !k[0])     return 10'b0000010010;
        if (k == 11)                        return 10'b0000001111;
        return 10'b0;
    endfunction

    // Expected {c2,c3,c4} for each qbits value in RECODE.
    logic [2:0] exp_rec [8] = '{3'b000, 3'b100, 3'b100, 3'b101,
                                 3'b111, 3'b110, 3'b110, 3'b000};

    // Runs one product through the real datapath; checks OUT timing and value.
    task automatic run_product(input logic [7:0] m, input logic [7:0] q,
                               input logic [16:0] exp_prod, input string tag);
        int cyc;
        bit seen;
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        seen  = 0;
        while (!seen && cyc < 30) begin
            if (c6 && c7) begin
                seen = 1;
                check({tag, "_value"}, 32'(outbus), 32'(exp_prod));
                check({tag, "_cycle"}, 32'(cyc), 32'd11);
            end
            tick();
            cyc++;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst_b    = 1'b0;
        start    = 1'b1;
        use_dp   = 1'b0;
        qbits_tb = 3'b000;
        mplier   = 8'd0;
        mcand    = 8'd0;

        // Reset held with start high: everything quiet.
        tick();
        check("reset_outs_a", 32'(outs()), 32'd0);
        tick();
        check("reset_outs_b", 32'(outs()), 32'd0);
        start = 1'b0;
        rst_b = 1'b1;
        tick();
        check("idle_after_reset", 32'(outs()), 32'd0);

        // Full sequence, qbits = 000.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("seq_cyc%0d", k), 32'(outs()), 32'(exp_vec(k)));
            tick();
        end

        // Start pulses at cycles 5 and 9 must not disturb the sequence.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("busy_start_cyc%0d", k), 32'(outs()), 32'(exp_vec(k)));
            start = (k == 5 || k == 9);
            tick();
        end
        start = 1'b0;

        // Recoding sweep: two runs cover the 8 qbits values in RECODE cycles.
        for (int run = 0; run < 2; run++) begin
            qbits_tb = 3'b000;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (k >= 3 && k <= 9 && k[0]) begin
                    qbits_tb = 3'(run * 4 + (k - 3) / 2);
                    #1;
                    check($sformatf("recode_q%0d", qbits_tb),
                          32'({c2, c3, c4}), 32'(exp_rec[qbits_tb]));
                    check($sformatf("recode_busy_q%0d", qbits_tb), 32'(busy), 32'd1);
                end else if (k >= 4 && k <= 10) begin
                    check($sformatf("shift_noadd_cyc%0d", k),
                          32'({c2, c3, c4, c5}), 32'b0001);
                end
                tick();
            end
        end
        qbits_tb = 3'b000;

        // End-to-end with the datapath model.
        use_dp = 1'b1;
        run_product(8'd7, 8'd3, 17'd21, "mul_7x3");
        tick();
        run_product(8'hFB, 8'h06, 17'h1FFE2, "mul_m5x6");
        tick();
        use_dp = 1'b0;

        // Reset during the SHIFT of cycle 6.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        check("pre_reset_shift", 32'(outs()), 32'(exp_vec(6)));
        rst_b = 1'b0;
        #1;
        check("midreset_drop", 32'(outs()), 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        check("after_reset_idle", 32'(outs()), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_init", 32'(outs()), 32'(exp_vec(1)));
        tick();
        check("restart_loadm", 32'(outs()), 32'(exp_vec(2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_r4_ctrl.md
# booth_r4_ctrl

Control sequencer for the radix-4 Booth multiplier datapath. It drives the c0–c7 strobes that the accumulator A, multiplier Q, and multiplicand M registers, the adder, and the output bus drivers consume. It reads the Booth recoding bits Q[1], Q[0], Q[-1] back from the datapath and issues one add/subtract decision and one 2-bit arithmetic shift per iteration. It then places the 17-bit product onto outbus.

## Interface
- OPW, default 8: operand width; must be even. Iteration count is OPW/2; counter width is clog2(OPW/2), minimum 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  reset: asynchronous, active-low.
- start  in  1  request a multiplication; sampled only in IDLE.
- qbits  in  3  {Q[1], Q[0], Q[-1]} from the datapath registers.
- c0  out  1  clear A, clear Q[-1], load Q from inbus.
- c1  out  1  load M from inbus.
- c2  out  1  load A from adder output.
- c3  out  1  adder subtracts (A − operand); valid only with c2.
- c4  out  1  adder operand is 2·M instead of M; valid only with c2.
- c5  out  1  arithmetic shift of {A, Q, Q[-1]} right by 2.
- c6  out  1  A drives outbus[16:8].
- c7  out  1  Q drives outbus[7:0].
- busy  out  1  high from INIT through OUT inclusive.
- done  out  1  one-cycle pulse, coincident with OUT.

## Operation
- States: IDLE, INIT, LOADM, RECODE, SHIFT, OUT.
- IDLE → INIT when start = 1. Otherwise IDLE holds.
- INIT asserts c0 and clears the counter. INIT → LOADM.
- LOADM asserts c1. LOADM → RECODE.
- RECODE decodes qbits:
  - 000 and 111: no strobes.
  - 001 and 010: c2.
  - 011: c2 and c4.
  - 100: c2, c3, and c4.
  - 101 and 110: c2 and c3.
- RECODE → SHIFT unconditionally. RECODE is always exactly one cycle, so timing is data-independent.
- SHIFT asserts c5.
  - If the counter equals OPW/2 − 1: SHIFT → OUT.
  - Otherwise: increment the counter, SHIFT → RECODE.
- OUT asserts c6, c7, and done. OUT → IDLE.
- Outputs are Moore decodes of state. c2, c3, and c4 are additionally gated by qbits, which come from registers and are stable throughout RECODE.
- c3 and c4 are 0 in every state other than RECODE. At most one of the groups {c0, c1, c2, c5, c6/c7} is active in any cycle.
- start while busy = 1 is ignored. It is neither queued nor able to restart the sequence.

## Timing
- Reset: state IDLE, counter 0. c0–c7, busy, and done are all 0.
- Reset asserted mid-operation: all strobes drop immediately (asynchronous). The FSM restarts from IDLE after rst_b rises. A partial product is discarded.
- Cycle numbering: cycle 0 is the edge that samples start = 1.
  - INIT is cycle 1.
  - LOADM is cycle 2.
  - Iteration k (k = 0 … OPW/2 − 1): RECODE at cycle 3 + 2k, SHIFT at cycle 4 + 2k.
  - OUT is cycle OPW + 3. For OPW = 8, that is cycle 11.
  - Back in IDLE at OPW + 4. A new start can be sampled there, so back-to-back throughput is one product per OPW + 4 cycles.
- inbus must carry the multiplier during the c0 cycle and the multiplicand during the c1 cycle. The bench or top level sequences inbus from these strobes.
- outbus holds the valid product only during the single OUT cycle, while c6 and c7 are high. The receiver captures it on that edge.

## Test plan
- Reset check: hold rst_b = 0 with start = 1 → c0–c7, busy, and done are all 0; state stays IDLE.
- Full sequence, OPW = 8, qbits held at 000: start for one cycle →
  - c0 at cycle 1, c1 at cycle 2;
  - c5 at cycles 4, 6, 8, 10;
  - c2 never asserted;
  - c6, c7, and done at cycle 11;
  - busy high for cycles 1–11.
- Recoding sweep: present each of the 8 qbits values in successive RECODE cycles → c2/c3/c4 match the table in Operation. Examples: 011 gives c2 = 1, c3 = 0, c4 = 1; 110 gives c2 = 1, c3 = 1, c4 = 0.
- End-to-end with the datapath: 7 × 3 → outbus = 17'd21 in OUT. −5 × 6 (M = 8'hFB, Q = 8'h06) → outbus = 17'h1FFE2 (−30).
- Start during busy: pulse start at cycles 5 and 9 → the sequence is unchanged, and OUT still occurs at cycle 11 only.
- Reset mid-operation: drop rst_b during the SHIFT of cycle 6 → c5 falls in the same cycle. After release, IDLE. A new start then produces c0 exactly one cycle later.
